// File: rtl/mem_access_pkg.sv
// Shared codes for the MEM-stage load/store unit: opcodes, memory addressing
// modes, fault causes, FSM states and opcode decode helpers.
package mem_access_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LH  = 3'b001,
        OP_LW  = 3'b010,
        OP_LBU = 3'b100,
        OP_LHU = 3'b101
    } load_op_e;

    typedef enum logic [1:0] {
        OP_SB = 2'b00,
        OP_SH = 2'b01,
        OP_SW = 2'b10
    } store_op_e;

    typedef enum logic [1:0] {
        MEM_WORD = 2'b00,
        MEM_HALF = 2'b01,
        MEM_BYTE = 2'b11
    } mem_mode_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_MISALIGN = 2'b01,
        CAUSE_ILLEGAL  = 2'b10,
        CAUSE_RANGE    = 2'b11
    } fault_cause_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    // Stores only look at op[1:0]; an illegal store code maps to WORD but faults anyway.
    function automatic logic [1:0] access_mode(input logic is_store, input logic [2:0] op);
        logic [1:0] mode;
        mode = MEM_WORD;
        if (is_store) begin
            case (op[1:0])
                OP_SB:   mode = MEM_BYTE;
                OP_SH:   mode = MEM_HALF;
                default: mode = MEM_WORD;
            endcase
        end else begin
            case (op)
                OP_LB, OP_LBU: mode = MEM_BYTE;
                OP_LH, OP_LHU: mode = MEM_HALF;
                default:       mode = MEM_WORD;
            endcase
        end
        return mode;
    endfunction

    function automatic logic op_illegal(input logic is_store, input logic [2:0] op);
        if (is_store)
            return (op[1:0] == 2'b11);
        return (op inside {3'b011, 3'b110, 3'b111});
    endfunction

    function automatic logic [2:0] access_size(input logic [1:0] mode);
        case (mode)
            MEM_BYTE: return 3'd1;
            MEM_HALF: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Combinational load-data extension (sign/zero) from the raw memory word.
// Also used by the forwarding path, so it stays free of any state.
module load_extend
    import mem_access_pkg::*;
#(
    parameter int NB_DATA = 32
) (
    input  logic [2:0]         op_i,
    input  logic [NB_DATA-1:0] raw_i,
    output logic [NB_DATA-1:0] data_o
);

    always_comb begin
        data_o = raw_i;
        case (op_i)
            OP_LB:   data_o = {{(NB_DATA-8){raw_i[7]}}, raw_i[7:0]};
            OP_LBU:  data_o = {{(NB_DATA-8){1'b0}}, raw_i[7:0]};
            OP_LH:   data_o = {{(NB_DATA-16){raw_i[15]}}, raw_i[15:0]};
            OP_LHU:  data_o = {{(NB_DATA-16){1'b0}}, raw_i[15:0]};
            default: data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: accepts one request, checks it, drives the
// data memory for N_WAIT cycles and returns one write-back pulse.
// Optional macro MEM_ACCESS_BOUNDS_CHECK_EN adds an out-of-range fault (cause 11).
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int NB_DATA    = 32,
    parameter int N_ADDRESS  = 64,
    parameter int NB_ADDRESS = $clog2(N_ADDRESS),
    parameter int N_WAIT     = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_is_store,
    input  logic [2:0]            i_op,
    input  logic [NB_DATA-1:0]    i_addr,
    input  logic [NB_DATA-1:0]    i_store_data,
    input  logic [4:0]            i_rd,
    input  logic                  i_flush,
    output logic [NB_ADDRESS-1:0] o_mem_r_addr,
    output logic [NB_ADDRESS-1:0] o_mem_w_addr,
    output logic                  o_mem_r_en,
    output logic                  o_mem_w_en,
    output logic [1:0]            o_mem_r_addressing,
    output logic [1:0]            o_mem_w_addressing,
    output logic [NB_DATA-1:0]    o_mem_w_data,
    input  logic [NB_DATA-1:0]    i_mem_r_data,
    output logic                  o_wb_valid,
    output logic                  o_wb_we,
    output logic [NB_DATA-1:0]    o_wb_data,
    output logic [4:0]            o_wb_rd,
    output logic                  o_fault,
    output logic [1:0]            o_fault_cause
);

    localparam int NB_CNT = 4;
    localparam logic [NB_CNT-1:0] LAST_CNT = NB_CNT'(N_WAIT - 1);

    function automatic logic [NB_DATA-1:0] store_mask(input logic [1:0] mode,
                                                      input logic [NB_DATA-1:0] d);
        logic [NB_DATA-1:0] m;
        m = d;
        if (mode == MEM_BYTE)
            m = {{(NB_DATA-8){1'b0}}, d[7:0]};
        else if (mode == MEM_HALF)
            m = {{(NB_DATA-16){1'b0}}, d[15:0]};
        return m;
    endfunction

    state_e                  state_q, state_d;
    logic [NB_CNT-1:0]       cnt_q, cnt_d;
    logic                    flush_q, flush_d;

    logic                    is_store_q;
    logic [2:0]              op_q;
    logic [1:0]              mode_q;
    logic [NB_ADDRESS-1:0]   addr_q;
    logic [NB_DATA-1:0]      wdata_q;
    logic [NB_DATA-1:0]      rdata_q;
    logic [4:0]              rd_q;
    logic                    fault_q;
    logic [1:0]              cause_q;

    logic                    accept;
    logic                    in_access;
    logic                    in_resp;
    logic                    last_access;
    logic                    flushed;
    logic [1:0]              req_mode;
    logic                    req_illegal;
    logic                    req_misalign;
    logic                    req_range;
    logic [1:0]              req_cause;
    logic                    req_fault;
    logic [NB_DATA-1:0]      ext_data;

    assign accept      = i_req_valid && (state_q == ST_IDLE);
    assign in_access   = (state_q == ST_ACCESS);
    assign in_resp     = (state_q == ST_RESP);
    assign last_access = in_access && (cnt_q >= LAST_CNT);

    assign req_mode     = access_mode(i_is_store, i_op);
    assign req_illegal  = op_illegal(i_is_store, i_op);
    assign req_misalign = ((req_mode == MEM_HALF) && i_addr[0]) ||
                          ((req_mode == MEM_WORD) && (i_addr[1:0] != 2'b00));

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
    localparam logic [NB_DATA:0] ADDR_LIMIT = (NB_DATA+1)'(N_ADDRESS);
    logic [NB_DATA:0] req_end;
    // One extra bit so the end address never wraps; high address bits also trip this.
    assign req_end   = {1'b0, i_addr} + {{(NB_DATA-2){1'b0}}, access_size(req_mode)};
    assign req_range = (req_end > ADDR_LIMIT);
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^i_addr[NB_DATA-1:NB_ADDRESS];
    assign req_range      = 1'b0;
`endif

    always_comb begin
        req_cause = CAUSE_NONE;
        if (req_illegal)
            req_cause = CAUSE_ILLEGAL;
        else if (req_misalign)
            req_cause = CAUSE_MISALIGN;
        else if (req_range)
            req_cause = CAUSE_RANGE;
    end

    assign req_fault = (req_cause != CAUSE_NONE);

    load_extend #(
        .NB_DATA (NB_DATA)
    ) u_load_extend (
        .op_i   (op_q),
        .raw_i  (i_mem_r_data),
        .data_o (ext_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flush_d = flush_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    flush_d = 1'b0;
                    state_d = req_fault ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (i_flush)
                    flush_d = 1'b1;
                if (last_access) begin
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (i_flush)
                    flush_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
        end
    end

    // Request fields and load data carry no reset; outputs are gated by state.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            is_store_q <= i_is_store;
            op_q       <= i_op;
            mode_q     <= req_mode;
            addr_q     <= i_addr[NB_ADDRESS-1:0];
            wdata_q    <= store_mask(req_mode, i_store_data);
            rd_q       <= i_rd;
            fault_q    <= req_fault;
            cause_q    <= req_cause;
        end
        if (last_access)
            rdata_q <= ext_data;
    end

    assign flushed = flush_q || i_flush;

    assign o_req_ready        = (state_q == ST_IDLE);
    assign o_mem_r_en         = in_access && !is_store_q;
    assign o_mem_w_en         = in_access && is_store_q && (cnt_q == '0);
    assign o_mem_r_addr       = in_access ? addr_q : '0;
    assign o_mem_w_addr       = in_access ? addr_q : '0;
    assign o_mem_r_addressing = in_access ? mode_q : MEM_WORD;
    assign o_mem_w_addressing = in_access ? mode_q : MEM_WORD;
    assign o_mem_w_data       = in_access ? wdata_q : '0;

    assign o_wb_valid    = in_resp && !flushed;
    assign o_wb_we       = in_resp && !flushed && !is_store_q && !fault_q;
    assign o_wb_data     = (in_resp && !is_store_q && !fault_q) ? rdata_q : '0;
    assign o_wb_rd       = in_resp ? rd_q : 5'd0;
    assign o_fault       = in_resp && fault_q && !flushed;
    assign o_fault_cause = in_resp ? cause_q : CAUSE_NONE;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit (N_WAIT=3) with a small byte-addressed
// little-endian memory model attached to the memory ports.
module tb_mem_access_unit;

    localparam int NB_DATA    = 32;
    localparam int N_ADDRESS  = 64;
    localparam int NB_ADDRESS = 6;
    localparam int N_WAIT     = 3;

    logic                  clk = 1'b0;
    logic                  i_reset = 1'b1;
    logic                  i_req_valid = 1'b0;
    logic                  o_req_ready;
    logic                  i_is_store = 1'b0;
    logic [2:0]            i_op = 3'b000;
    logic [NB_DATA-1:0]    i_addr = '0;
    logic [NB_DATA-1:0]    i_store_data = '0;
    logic [4:0]            i_rd = '0;
    logic                  i_flush = 1'b0;
    logic [NB_ADDRESS-1:0] o_mem_r_addr, o_mem_w_addr;
    logic                  o_mem_r_en, o_mem_w_en;
    logic [1:0]            o_mem_r_addressing, o_mem_w_addressing;
    logic [NB_DATA-1:0]    o_mem_w_data;
    logic [NB_DATA-1:0]    i_mem_r_data;
    logic                  o_wb_valid, o_wb_we;
    logic [NB_DATA-1:0]    o_wb_data;
    logic [4:0]            o_wb_rd;
    logic                  o_fault;
    logic [1:0]            o_fault_cause;

    mem_access_unit #(
        .NB_DATA(NB_DATA), .N_ADDRESS(N_ADDRESS), .NB_ADDRESS(NB_ADDRESS), .N_WAIT(N_WAIT)
    ) dut (
        .i_clk(clk), .i_reset(i_reset), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_is_store(i_is_store), .i_op(i_op), .i_addr(i_addr), .i_store_data(i_store_data),
        .i_rd(i_rd), .i_flush(i_flush),
        .o_mem_r_addr(o_mem_r_addr), .o_mem_w_addr(o_mem_w_addr),
        .o_mem_r_en(o_mem_r_en), .o_mem_w_en(o_mem_w_en),
        .o_mem_r_addressing(o_mem_r_addressing), .o_mem_w_addressing(o_mem_w_addressing),
        .o_mem_w_data(o_mem_w_data), .i_mem_r_data(i_mem_r_data),
        .o_wb_valid(o_wb_valid), .o_wb_we(o_wb_we), .o_wb_data(o_wb_data), .o_wb_rd(o_wb_rd),
        .o_fault(o_fault), .o_fault_cause(o_fault_cause)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory model ----------------
    logic [7:0] mem [0:63];
    logic [5:0] ra1, ra2, ra3, wa1, wa2, wa3;
    assign ra1 = o_mem_r_addr + 6'd1;
    assign ra2 = o_mem_r_addr + 6'd2;
    assign ra3 = o_mem_r_addr + 6'd3;
    assign wa1 = o_mem_w_addr + 6'd1;
    assign wa2 = o_mem_w_addr + 6'd2;
    assign wa3 = o_mem_w_addr + 6'd3;

    assign i_mem_r_data = !o_mem_r_en ? 32'h0 :
        (o_mem_r_addressing == 2'b11) ? {24'h0, mem[o_mem_r_addr]} :
        (o_mem_r_addressing == 2'b01) ? {16'h0, mem[ra1], mem[o_mem_r_addr]} :
        {mem[ra3], mem[ra2], mem[ra1], mem[o_mem_r_addr]};

    always @(posedge clk) begin
        if (o_mem_w_en) begin
            mem[o_mem_w_addr] <= o_mem_w_data[7:0];
            if (o_mem_w_addressing != 2'b11) mem[wa1] <= o_mem_w_data[15:8];
            if (o_mem_w_addressing == 2'b00) begin
                mem[wa2] <= o_mem_w_data[23:16];
                mem[wa3] <= o_mem_w_data[31:24];
            end
        end
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        fault;
        logic [1:0]  cause;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    // Memory-side activity counters, updated away from the active edge.
    int r_cnt = 0, r_rise = 0, w_cnt = 0;
    logic r_prev = 1'b0;
    logic [5:0]  last_r_addr = '0, last_w_addr = '0;
    logic [1:0]  last_w_mode = '0;
    logic [31:0] last_w_data = '0;

    always @(negedge clk) begin
        if (o_mem_r_en) begin
            r_cnt++;
            last_r_addr = o_mem_r_addr;
            if (!r_prev) r_rise++;
        end
        if (o_mem_w_en) begin
            w_cnt++;
            last_w_addr = o_mem_w_addr;
            last_w_mode = o_mem_w_addressing;
            last_w_data = o_mem_w_data;
        end
        r_prev = o_mem_r_en;
    end

    always @(negedge clk) begin
        if (o_wb_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wb_valid", 32'(o_wb_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wb_we",    32'(o_wb_we),       32'(e.we));
                check("wb_data",  o_wb_data,          e.data);
                check("wb_rd",    32'(o_wb_rd),       32'(e.rd));
                check("wb_fault", 32'(o_fault),       32'(e.fault));
                check("wb_cause", 32'(o_fault_cause), 32'(e.cause));
                check("wb_cycle", 32'(cyc),           32'(e.cyc));
            end
        end else begin
            check("quiet_wb", {30'h0, o_wb_we, o_fault}, 32'h0);
        end
    end

    // ---------------- stimulus helpers ----------------
    int last_acc = 0;
    int snap_r = 0, snap_rise = 0, snap_w = 0;

    task automatic snap();
        snap_r = r_cnt; snap_rise = r_rise; snap_w = w_cnt;
    endtask

    task automatic txn(input logic st, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] sd, input logic [4:0] rd, input logic [31:0] exp_data,
                       input logic [1:0] exp_cause, input logic push, input logic hold);
        exp_t e;
        int n;
        i_req_valid = 1'b1; i_is_store = st; i_op = op; i_addr = addr;
        i_store_data = sd; i_rd = rd;
        n = 0;
        while (!o_req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!o_req_ready) begin
            check("accept_timeout", 32'(o_req_ready), 32'd1);
        end else begin
            last_acc = cyc;
            e.fault = (exp_cause != 2'b00);
            e.cause = exp_cause;
            e.we    = !st && !e.fault;
            e.data  = e.we ? exp_data : 32'h0;
            e.rd    = rd;
            e.cyc   = cyc + (e.fault ? 1 : N_WAIT + 1);
            if (push) exp_q.push_back(e);
        end
        @(negedge clk);
        if (!hold) i_req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int exp_gap);
        int n;
        n = 0;
        while (!o_req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(cyc - last_acc), 32'(exp_gap));
    endtask

    task automatic do_load(input logic [2:0] op, input logic [31:0] addr,
                           input logic [4:0] rd, input logic [31:0] exp_data);
        snap();
        txn(1'b0, op, addr, 32'h0, rd, exp_data, 2'b00, 1'b1, 1'b0);
        wait_idle("ld_ready_gap", N_WAIT + 2);
        check("ld_r_cycles", 32'(r_cnt - snap_r), 32'(N_WAIT));
        check("ld_r_rise",   32'(r_rise - snap_rise), 32'd1);
        check("ld_w_cycles", 32'(w_cnt - snap_w), 32'd0);
    endtask

    task automatic do_store(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] sd,
                            input logic [31:0] exp_wdata, input logic [1:0] exp_mode);
        snap();
        txn(1'b1, {1'b0, op}, addr, sd, 5'd7, 32'h0, 2'b00, 1'b1, 1'b0);
        wait_idle("st_ready_gap", N_WAIT + 2);
        check("st_w_cycles", 32'(w_cnt - snap_w), 32'd1);
        check("st_r_cycles", 32'(r_cnt - snap_r), 32'd0);
        check("st_w_mode",   32'(last_w_mode), 32'(exp_mode));
        check("st_w_data",   last_w_data, exp_wdata);
        check("st_w_addr",   32'(last_w_addr), addr & 32'h3f);
    endtask

    task automatic do_fault(input logic st, input logic [2:0] op, input logic [31:0] addr,
                            input logic [1:0] cause);
        snap();
        txn(st, op, addr, 32'hFFFF_FFFF, 5'd21, 32'h0, cause, 1'b1, 1'b0);
        wait_idle("flt_ready_gap", 2);
        check("flt_r_cycles", 32'(r_cnt - snap_r), 32'd0);
        check("flt_w_cycles", 32'(w_cnt - snap_w), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int a1;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        mem[8] = 8'h80; mem[9] = 8'h7F; mem[10] = 8'hFF; mem[11] = 8'h01;

        repeat (3) @(negedge clk);
        check("reset_ready", 32'(o_req_ready), 32'd1);
        check("reset_ctrl", {22'h0, o_mem_r_en, o_mem_w_en, o_wb_valid, o_wb_we, o_fault,
                             o_fault_cause, o_mem_r_addressing[0], o_mem_w_addressing[0]}, 32'h0);
        check("reset_data", o_wb_data | o_mem_w_data | {27'h0, o_wb_rd}, 32'h0);
        i_reset = 1'b0;
        @(negedge clk);

        do_load(3'b000, 32'd8,  5'd3, 32'hFFFF_FF80);
        do_load(3'b100, 32'd8,  5'd4, 32'h0000_0080);
        do_load(3'b001, 32'd8,  5'd5, 32'h0000_7F80);
        do_load(3'b000, 32'd9,  5'd6, 32'h0000_007F);
        do_load(3'b001, 32'd10, 5'd8, 32'h0000_01FF);
        do_load(3'b000, 32'd10, 5'd9, 32'hFFFF_FFFF);
        do_load(3'b100, 32'd10, 5'd10, 32'h0000_00FF);
        do_load(3'b010, 32'd8,  5'd11, 32'h01FF_7F80);

        do_store(2'b01, 32'd4, 32'h1234_ABCD, 32'h0000_ABCD, 2'b01);
        do_load(3'b101, 32'd4, 5'd12, 32'h0000_ABCD);
        do_load(3'b001, 32'd4, 5'd13, 32'hFFFF_ABCD);
        do_store(2'b00, 32'd6, 32'h1234_56EE, 32'h0000_00EE, 2'b11);
        do_load(3'b010, 32'd4, 5'd14, 32'h00EE_ABCD);

        do_fault(1'b0, 3'b010, 32'd6, 2'b01);
        do_fault(1'b0, 3'b110, 32'd0, 2'b10);
        do_fault(1'b0, 3'b011, 32'd1, 2'b10);
        do_fault(1'b1, 3'b011, 32'd0, 2'b10);
        do_fault(1'b1, 3'b001, 32'd5, 2'b01);
        do_fault(1'b0, 3'b101, 32'd3, 2'b01);

        // back-to-back with valid held across the busy window
        snap();
        txn(1'b0, 3'b010, 32'd0, 32'h0, 5'd1, 32'h4433_2211, 2'b00, 1'b1, 1'b1);
        a1 = last_acc;
        txn(1'b0, 3'b010, 32'd4, 32'h0, 5'd2, 32'h00EE_ABCD, 2'b00, 1'b1, 1'b0);
        check("b2b_accept_gap", 32'(last_acc - a1), 32'(N_WAIT + 2));
        wait_idle("b2b_ready_gap", N_WAIT + 2);
        check("b2b_r_rise",   32'(r_rise - snap_rise), 32'd2);
        check("b2b_r_cycles", 32'(r_cnt - snap_r), 32'(2 * N_WAIT));

        // flushed store still writes memory but returns nothing
        snap();
        txn(1'b1, 3'b010, 32'd12, 32'hCAFE_BABE, 5'd15, 32'h0, 2'b00, 1'b0, 1'b0);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        wait_idle("flush_ready_gap", N_WAIT + 2);
        check("flush_w_cycles", 32'(w_cnt - snap_w), 32'd1);
        do_load(3'b010, 32'd12, 5'd16, 32'hCAFE_BABE);

        // reset in cycle 2 of a load
        txn(1'b0, 3'b010, 32'd0, 32'h0, 5'd17, 32'h0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        check("rst_mid_r_en",  32'(o_mem_r_en), 32'd0);
        check("rst_mid_ready", 32'(o_req_ready), 32'd1);
        i_reset = 1'b0;
        @(negedge clk);

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
        do_fault(1'b0, 3'b010, 32'd64, 2'b11);
        do_fault(1'b0, 3'b001, 32'd64, 2'b11);
        do_load(3'b010, 32'd60, 5'd18, 32'h0000_0000);
`else
        do_load(3'b010, 32'd64, 5'd18, 32'h4433_2211);
        check("wrap_r_addr", 32'(last_r_addr), 32'd0);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
